// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arbiter_pkg;

   localparam int NUM_PORTS          = 2;
   localparam int DATA_W             = 16;
   localparam int ADDR_W             = 16;
   localparam int DEF_TIMEOUT_CYCLES = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the
// port that was not granted last.
module rr_arb2
   import mem_arbiter_pkg::*;
(
   input  logic [NUM_PORTS-1:0] req,
   input  logic                 last,
   output logic [NUM_PORTS-1:0] gnt
);

   // One-hot grant from the request pair and the last-grant pointer.
   always_comb begin
      gnt = '0;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = last ? 2'b01 : 2'b10;
         default: gnt = '0;
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two requesters onto one memory port: grant, issue one cycle,
// wait for ready (bounded by TIMEOUT_CYCLES), then a one-cycle ack.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        p0_req,
   input  logic        p0_we,
   input  logic [15:0] p0_addr,
   input  logic [15:0] p0_wdata,
   output logic        p0_ack,
   output logic [15:0] p0_rdata,
   input  logic        p1_req,
   input  logic        p1_we,
   input  logic [15:0] p1_addr,
   input  logic [15:0] p1_wdata,
   output logic        p1_ack,
   output logic [15:0] p1_rdata,
   output logic        mem_w,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   input  logic        mem_ready,
   output logic        busy,
   output logic        err
);

   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 5) ? $clog2(TIMEOUT_CYCLES + 1) : 5;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t              state;
   state_t              next_state;
   logic [1:0]          gnt;
   logic                gnt_q;     // granted port index: 0 = p0, 1 = p1
   logic                last_q;    // port granted most recently
   logic                we_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [CNT_W-1:0]    wait_cnt;
   logic                timeout;
   logic                err_q;
   logic [DATA_W-1:0]   rdata0_q;
   logic [DATA_W-1:0]   rdata1_q;

   rr_arb2 u_rr_arb2 (
      .req  ({p1_req, p0_req}),
      .last (last_q),
      .gnt  (gnt)
   );

   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign err       = err_q;
   assign p0_rdata  = rdata0_q;
   assign p1_rdata  = rdata1_q;

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   // Next-state decode and state-derived outputs (strobe, acks, busy).
   always_comb begin
      next_state = state;
      timeout    = 1'b0;
      mem_w      = 1'b0;
      p0_ack     = 1'b0;
      p1_ack     = 1'b0;
      case (state)
         IDLE: begin
            if (|gnt) next_state = ISSUE;
         end
         ISSUE: begin
            mem_w      = we_q;
            next_state = WAIT;
         end
         WAIT: begin
            if (mem_ready) begin
               next_state = DONE;
            end else if (wait_cnt == CNT_LAST) begin
               next_state = DONE;
               timeout    = 1'b1;
            end
         end
         DONE: begin
            p0_ack     = ~gnt_q;
            p1_ack     = gnt_q;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
      busy = (state != IDLE);
   end

   // Transfer latches, wait counter, read-data capture and sticky error.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         gnt_q    <= 1'b0;
         last_q   <= 1'b1;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         wait_cnt <= '0;
         err_q    <= 1'b0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         if (state == IDLE && |gnt) begin
            gnt_q   <= gnt[1];
            last_q  <= gnt[1];
            we_q    <= gnt[1] ? p1_we    : p0_we;
            addr_q  <= gnt[1] ? p1_addr  : p0_addr;
            wdata_q <= gnt[1] ? p1_wdata : p0_wdata;
         end
         wait_cnt <= (state == WAIT && next_state == WAIT) ? wait_cnt + 1'b1 : '0;
         if (state == WAIT && mem_ready && !we_q) begin
            if (gnt_q) rdata1_q <= mem_rdata;
            else       rdata0_q <= mem_rdata;
         end
         if (timeout) err_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed plus randomized checks of mem_arbiter against a transaction-level
// reference (expected memory contents, per-port read data, latency, err).
module tb_mem_arbiter;

   localparam int TMO = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        p0_req, p0_we, p1_req, p1_we;
   logic [15:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
   logic        p0_ack, p1_ack;
   logic [15:0] p0_rdata, p1_rdata;
   logic        mem_w;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_ready;
   logic        busy, err;

   int vectors     = 0;
   int miscompares = 0;

   // Memory model (device side) and reference expectations.
   logic [15:0] mem [65536];
   logic [15:0] written [logic [15:0]];
   logic [15:0] exp_rdata [2];
   logic        err_exp;

   mem_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_ack(p0_ack), .p0_rdata(p0_rdata),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_ack(p1_ack), .p1_rdata(p1_rdata),
      .mem_w(mem_w), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr];
   always @(posedge clk) if (mem_w) mem[mem_addr] = mem_wdata;

   function automatic logic [15:0] init_val(input logic [15:0] a);
      return (a == 16'h0010) ? 16'h1234 : (a ^ 16'h5A5A);
   endfunction

   function automatic logic [15:0] ref_read(input logic [15:0] a);
      return written.exists(a) ? written[a] : init_val(a);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int port, input logic req, input logic we,
                        input logic [15:0] addr, input logic [15:0] wdata);
      if (port == 0) begin
         p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata;
      end else begin
         p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata;
      end
   endtask

   task automatic reset_dut();
      rst_n = 1'b0;
      drive(0, 1'b0, 1'b0, '0, '0);
      drive(1, 1'b0, 1'b0, '0, '0);
      mem_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      exp_rdata[0] = '0;
      exp_rdata[1] = '0;
      err_exp = 1'b0;
   endtask

   // One transfer. d = WAIT cycles the memory holds ready low; o = 1 when
   // the call starts in the ack cycle of a previous transfer on a held req.
   task automatic xfer(input int port, input logic we, input logic [15:0] addr,
                       input logic [15:0] wdata, input int d, input bit keep_req, input int o);
      int ack_k, exp_k, wpulses, xack;
      logic [15:0] waddr, wdat, rd_obs, ma_obs;
      logic err_obs;
      bit tmo;
      drive(port, 1'b1, we, addr, wdata);
      mem_ready = 1'b0;
      ack_k = -1; wpulses = 0; xack = 0;
      waddr = '0; wdat = '0; rd_obs = '0; ma_obs = '0; err_obs = 1'b0;
      for (int k = 1; k <= 60 && ack_k < 0; k++) begin
         @(negedge clk);
         if (k == 2 + o + d) mem_ready = 1'b1;
         if (mem_w) begin wpulses++; waddr = mem_addr; wdat = mem_wdata; end
         if ((port == 0) ? p1_ack : p0_ack) xack++;
         if ((port == 0) ? p0_ack : p1_ack) begin
            ack_k   = k;
            rd_obs  = (port == 0) ? p0_rdata : p1_rdata;
            ma_obs  = mem_addr;
            err_obs = err;
         end
      end
      tmo   = (d >= TMO);
      exp_k = tmo ? (2 + o + TMO) : (3 + o + d);
      if (we) written[addr] = wdata;
      else if (!tmo) exp_rdata[port] = ref_read(addr);
      if (tmo) err_exp = 1'b1;
      chk("ack_latency", ack_k, exp_k);
      chk("other_ack", xack, 0);
      chk("mem_w_pulses", wpulses, {31'd0, we});
      if (we) begin
         chk("write_addr", waddr, addr);
         chk("write_data", wdat, wdata);
      end
      chk("rdata", rd_obs, exp_rdata[port]);
      chk("addr_held", ma_obs, addr);
      chk("err", err_obs, err_exp);
      if (!keep_req) begin
         drive(port, 1'b0, we, addr, wdata);
         @(negedge clk);
         chk("ack_one_cycle", (port == 0) ? p0_ack : p1_ack, 1'b0);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: observed no finish, required finish");
      $fatal(1);
   end

   initial begin
      int both, quiet;
      int order [$];
      for (int i = 0; i < 65536; i++) mem[i] = init_val(16'(i));

      // Reset values
      reset_dut();
      chk("rst_busy", busy, 1'b0);
      chk("rst_mem_w", mem_w, 1'b0);
      chk("rst_mem_addr", mem_addr, 16'h0000);
      chk("rst_mem_wdata", mem_wdata, 16'h0000);
      chk("rst_p0_ack", p0_ack, 1'b0);
      chk("rst_p1_ack", p1_ack, 1'b0);
      chk("rst_p0_rdata", p0_rdata, 16'h0000);
      chk("rst_p1_rdata", p1_rdata, 16'h0000);
      chk("rst_err", err, 1'b0);

      // Basic read, write then read-back, back-to-back same-address reads
      xfer(0, 1'b0, 16'h0010, 16'h0000, 0, 1'b0, 0);
      chk("p0_read_1234", p0_rdata, 16'h1234);
      xfer(1, 1'b1, 16'h0020, 16'hBEEF, 1, 1'b0, 0);
      xfer(0, 1'b0, 16'h0020, 16'h0000, 0, 1'b0, 0);
      chk("p0_read_beef", p0_rdata, 16'hBEEF);
      xfer(0, 1'b0, 16'h0030, 16'h0000, 0, 1'b1, 0);
      xfer(0, 1'b0, 16'h0030, 16'h0000, 0, 1'b0, 1);
      // Ready on the last WAIT cycle before timeout: no error
      xfer(1, 1'b0, 16'h0010, 16'h0000, TMO - 1, 1'b0, 0);

      // Both requesters held from reset: strict alternation starting at p0
      reset_dut();
      drive(0, 1'b1, 1'b0, 16'h0010, '0);
      drive(1, 1'b1, 1'b0, 16'h0020, '0);
      mem_ready = 1'b1;
      both = 0;
      for (int k = 1; k <= 40 && order.size() < 4; k++) begin
         @(negedge clk);
         if (p0_ack && p1_ack) both++;
         if (p0_ack) order.push_back(0);
         if (p1_ack) order.push_back(1);
      end
      drive(0, 1'b0, 1'b0, 16'h0010, '0);
      drive(1, 1'b0, 1'b0, 16'h0020, '0);
      exp_rdata[0] = ref_read(16'h0010);
      exp_rdata[1] = ref_read(16'h0020);
      chk("rr_count", order.size(), 4);
      for (int i = 0; i < 4; i++)
         chk("rr_order", (i < order.size()) ? order[i] : -1, i % 2);
      chk("rr_overlap", both, 0);
      @(negedge clk);
      chk("rr_p0_rdata", p0_rdata, exp_rdata[0]);
      chk("rr_p1_rdata", p1_rdata, exp_rdata[1]);

      // Reset during WAIT aborts with no ack; the next request is normal
      drive(0, 1'b1, 1'b0, 16'h0030, '0);
      mem_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rstw_busy_before", busy, 1'b1);
      rst_n = 1'b0;
      drive(0, 1'b0, 1'b0, 16'h0030, '0);
      @(negedge clk);
      chk("rstw_busy", busy, 1'b0);
      chk("rstw_mem_w", mem_w, 1'b0);
      chk("rstw_p0_ack", p0_ack, 1'b0);
      chk("rstw_p0_rdata", p0_rdata, 16'h0000);
      rst_n = 1'b1;
      exp_rdata[0] = '0; exp_rdata[1] = '0; err_exp = 1'b0;
      quiet = 0;
      repeat (4) begin
         @(negedge clk);
         if (p0_ack || p1_ack) quiet++;
      end
      chk("rstw_no_ack", quiet, 0);
      xfer(0, 1'b0, 16'h0030, 16'h0000, 2, 1'b0, 0);

      // Timeout: ready held low beyond TIMEOUT_CYCLES; rdata kept, err sticky
      xfer(0, 1'b0, 16'h0010, 16'h0000, 0, 1'b0, 0);
      xfer(0, 1'b0, 16'h0020, 16'h0000, 20, 1'b0, 0);
      chk("tmo_rdata_kept", p0_rdata, 16'h1234);
      repeat (5) @(negedge clk);
      chk("err_sticky", err, 1'b1);
      xfer(1, 1'b1, 16'h0044, 16'h0BAD, 1, 1'b0, 0);
      reset_dut();
      chk("err_cleared", err, 1'b0);

      // Randomized transfers
      for (int n = 0; n < 40; n++) begin
         int port, d;
         logic we;
         logic [15:0] addr, wdata;
         port  = $urandom_range(0, 1);
         we    = 1'($urandom_range(0, 1));
         addr  = 16'h0040 + 16'($urandom_range(0, 7));
         wdata = 16'($urandom);
         d     = ($urandom_range(0, 7) == 0) ? TMO + $urandom_range(0, 3) : $urandom_range(0, 4);
         xfer(port, we, addr, wdata, d, 1'b0, 0);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 16, giving the maximum WAIT cycles before abandoning a transfer.
REQ-002 The block SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-003 The block SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-004 The block SHALL have ports p0_req / p1_req  input  1  requester N transfer request.
REQ-005 The block SHALL have ports p0_we / p1_we  input  1  1 = write, 0 = read.
REQ-006 The block SHALL have ports p0_addr / p1_addr  input  16  word address.
REQ-007 The block SHALL have ports p0_wdata / p1_wdata  input  16  write data.
REQ-008 The block SHALL have ports p0_ack / p1_ack  output  1  one-cycle completion pulse.
REQ-009 The block SHALL have ports p0_rdata / p1_rdata  output  16  read data, valid in the ack cycle and held until the next ack to that port.
REQ-010 The block SHALL have port mem_w  output  1  memory write strobe.
REQ-011 The block SHALL have ports mem_addr / mem_wdata  output  16  memory address and write data.
REQ-012 The block SHALL have ports mem_rdata  input  16  and  mem_ready  input  1, the memory read data and ready flag.
REQ-013 The block SHALL have ports busy  output  1 (state != IDLE) and err  output  1 (sticky timeout flag).

Function
REQ-014 The FSM SHALL have states IDLE, ISSUE, WAIT and DONE, encoded in 2 bits.
REQ-015 In IDLE with any req high, the block SHALL grant one port, latch its we/addr/wdata, and move to ISSUE on the next edge.
REQ-016 If only one req is high, that port SHALL be granted.
REQ-017 If both reqs are high, the port not granted last SHALL win; the last-grant pointer SHALL update on every grant.
REQ-018 ISSUE SHALL last exactly 1 cycle, driving mem_addr and mem_wdata from the latched values, with mem_w = latched we.
REQ-019 mem_w SHALL be high only in ISSUE (exactly one cycle per write) and low in all other states.
REQ-020 mem_addr SHALL hold the latched address from ISSUE through DONE, and hold its last value in IDLE.
REQ-021 WAIT SHALL move to DONE in the first cycle mem_ready = 1, sampling mem_rdata into the granted port's rdata register at that edge.
REQ-022 A 5-bit-minimum counter SHALL count WAIT cycles; at TIMEOUT_CYCLES consecutive cycles without mem_ready, the block SHALL go to DONE, set err, and leave that port's rdata unchanged.
REQ-023 DONE SHALL last 1 cycle, assert only the granted port's ack, then return to IDLE.
REQ-024 Minimum latency SHALL be 4 cycles from req sampled in IDLE to ack, with a new grant possible in the cycle after DONE.
REQ-025 A requester SHALL hold req and its fields stable until ack; a req still high in the cycle after ack SHALL be treated as a new request.
REQ-026 A req deasserted before ack SHALL NOT abort the transfer in progress.
REQ-027 An ungranted port's req SHALL wait, and the non-last-granted rule SHALL prevent starvation.
REQ-028 Write transfers SHALL also wait for mem_ready, and rdata SHALL NOT be updated for writes.
REQ-029 The two acks SHALL never be high in the same cycle.

Reset
REQ-030 While rst_n = 0 at an edge, the block SHALL set state IDLE, mem_w 0, mem_addr 0, mem_wdata 0, acks 0, rdata 0, err 0, timeout counter 0, and the last-grant pointer to p1 (so p0 wins the first tie).
REQ-031 A reset during ISSUE, WAIT or DONE SHALL abort the transfer with no ack issued and mem_w low from the reset edge.

Structure
REQ-032 A shared package SHALL hold the FSM state typedef and constants for port count (2), data/address width (16) and default TIMEOUT_CYCLES.
REQ-033 The round-robin grant logic SHALL be a sub-module rr_arb2 (inputs req[1:0] and last; outputs gnt[1:0]).
REQ-034 No memory array SHALL live inside mem_arbiter.

Verification
REQ-035 Scenario: p0 reads 0x0010 from a memory model holding 0x1234 -> mem_w stays 0, p0_ack fires 4 cycles after req, p0_rdata = 0x1234.
REQ-036 Scenario: p1 writes 0xBEEF to 0x0020 -> mem_w high exactly 1 cycle with mem_addr 0x0020, p1_ack pulses once, and a following p0 read of 0x0020 returns 0xBEEF.
REQ-037 Scenario: both reqs held high for 4 transfers after reset -> grants in order p0, p1, p0, p1, with no overlapping acks.
REQ-038 Scenario: model holds mem_ready = 0 for 20 cycles with TIMEOUT_CYCLES = 16 -> ack after 16 WAIT cycles, err = 1 and stays 1 until rst_n is low.
REQ-039 Scenario: rst_n pulled low during WAIT -> no ack, busy = 0 and mem_w = 0 after the edge, and the next request completes normally.
REQ-040 Scenario: p0 reads the same address twice back-to-back (ready stays 1) -> the second ack arrives at minimum latency with identical rdata.
